div_sequencer: RTL
==================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle controller for RV32M DIV/DIVU/REM/REMU in the execute stage. Accepts one op beside the ALU,
//  runs a radix-2 restoring divider for 32 iterations, and holds the pipeline stall until the result is ready.
//  Its result joins ALU_out on the execute writeback mux, selected by result_valid.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width. Iteration count = DATA_WIDTH. Counter width = $clog2(DATA_WIDTH)+1.
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           asynchronous active-low reset
//  flush         in   1           synchronous abort of any op in flight (branch mispredict / trap)
//  req_valid     in   1           divide op present in execute. Held while stall=1.
//  div_op        in   2           00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend      in   DATA_WIDTH  rs1 value (r_out1)
//  divisor       in   DATA_WIDTH  rs2 value (r_out2)
//  stall         out  1           freeze fetch/decode/execute registers
//  busy          out  1           FSM not in IDLE
//  result_valid  out  1           result valid this cycle. 1-cycle pulse.
//  result        out  DATA_WIDTH  quotient or remainder per div_op
// BEHAVIOUR
//  Reset: async, rst_n=0 -> state IDLE, counter 0, all datapath regs 0.
//   Outputs during and after reset: stall=0, busy=0, result_valid=0, result=0.
//  States:
//   IDLE -> PREP : req_valid=1, flush=0. Latch div_op and operands.
//   PREP -> DONE : special case. Set result directly.
//   PREP -> ITER : otherwise. For signed ops, latch |dividend| and |divisor| plus sign flags.
//   ITER (32 cycles): per cycle {rem,quo} <<= 1. If rem >= divisor then rem -= divisor, quo[0]=1.
//   ITER -> FIX : after 32 cycles.
//   FIX : signed ops only. Negate quotient if the operand signs differ. Remainder takes the dividend's sign.
//   FIX -> DONE.
//   DONE -> IDLE : result_valid=1, stall=0 so the pipeline advances this cycle.
//  Latency (accept cycle = cycle 0):
//   PREP at cycle 1, ITER cycles 2..33, FIX 34, DONE 35 -> result_valid in cycle 35.
//   Special case -> result_valid in cycle 2.
//  stall = (state IDLE & req_valid & ~flush) | state in {PREP, ITER, FIX}.
//  result: driven in DONE only, and holds its last value otherwise. Bench checks it only when result_valid=1.
//  Special cases (decided in PREP):
//   divisor=0: DIV/DIVU quotient=all ones. REM/REMU=dividend.
//   signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
//  Back-to-back: the op after DONE may be accepted the cycle after DONE (IDLE). No request is taken in DONE itself.
//  req_valid while busy: ignored. Operands are held by the stalled pipeline and are not re-sampled.
//  flush: in any non-IDLE state, next state is IDLE with no result_valid and stall=0 from the next cycle.
//   flush in IDLE suppresses acceptance. flush in DONE: result_valid is still 1 and the consumer discards it.
//  rst_n low mid-operation: immediate abort, outputs reset as above, no partial result.
//  Arithmetic: all unsigned inside ITER, with a DATA_WIDTH+1 bit subtract for the compare.
//   Negation = two's complement modulo 2^DATA_WIDTH.
// TESTING
//  DIVU 100/7: result_valid in cycle 35 with result=14. REMU same operands -> 2. stall high cycles 0..34, low in 35.
//  DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REM 7/-2 -> 1.
//  DIVU 5/0 -> 0xFFFFFFFF in cycle 2. REM 0x80000000/0xFFFFFFFF -> 0 in cycle 2.
//  flush in cycle 10 of DIV 1000/3 -> busy=0 and stall=0 from cycle 11, no result_valid.
//   A new DIVU 9/3 is accepted next and gives result 3.
//  rst_n low in cycle 20 -> immediate IDLE, outputs 0.
//   Back-to-back DIVU 6/3 then DIVU 8/2: results 2 then 4, pulses 36 cycles apart.
//  Random signed/unsigned operands incl. 0, 1, -1, 0x80000000 vs reference model. Check the stall/result_valid protocol every cycle.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer: radix-2 restoring divider that
// stalls the pipeline from acceptance until the result pulse.
//
// state | meaning
// IDLE  | waiting for a divide op; accepts when req_valid & ~flush
// PREP  | resolve special cases or load magnitudes and sign flags
// ITER  | one restoring shift/subtract step per cycle, DATA_WIDTH cycles
// FIX   | apply quotient/remainder signs for signed ops
// DONE  | result_valid pulse, pipeline released
module div_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall,
  output logic                  busy,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic [W-1:0]  result_q, result_d;

  logic          is_signed;
  logic [W-1:0]  dvd_abs, dvs_abs;
  logic [W:0]    rem_sh;
  logic [W+1:0]  diff;
  logic          fits;
  logic [W-1:0]  quo_fix, rem_fix;

  assign is_signed = ~op_q[0];
  assign dvd_abs   = (is_signed && dvd_q[W-1]) ? (~dvd_q + 1'b1) : dvd_q;
  assign dvs_abs   = (is_signed && dvs_q[W-1]) ? (~dvs_q + 1'b1) : dvs_q;

  // Shifted partial remainder can reach 2*divisor-1, so the compare needs a
  // borrow bit beyond the widened remainder.
  assign rem_sh  = {rem_q, quo_q[W-1]};
  assign diff    = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign fits    = ~diff[W+1];
  assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    result_d     = result_q;
    stall        = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (req_valid && !flush) begin
          stall   = 1'b1;
          op_d    = div_op;
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (dvs_q == '0) begin
          result_d = op_q[1] ? dvd_q : ALL_ONE;
          state_d  = S_DONE;
        end else if (is_signed && dvd_q == MIN_NEG && dvs_q == ALL_ONE) begin
          result_d = op_q[1] ? '0 : MIN_NEG;
          state_d  = S_DONE;
        end else begin
          quo_d     = dvd_abs;
          dvs_d     = dvs_abs;
          rem_d     = '0;
          cnt_d     = CW'(DATA_WIDTH);
          neg_quo_d = is_signed & (dvd_q[W-1] ^ dvs_q[W-1]);
          neg_rem_d = is_signed & dvd_q[W-1];
          state_d   = S_ITER;
        end
      end
      S_ITER: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = fits ? diff[W-1:0] : rem_sh[W-1:0];
          quo_d = {quo_q[W-2:0], fits};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // Pulse goes out even under flush; the consumer drops it.
        result_valid = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;

endmodule
